// File: rtl/ifid_skid_stage_if.sv
// IF/ID handshake bundle: fetch-side valid/ready, flush, and decode-side fields.
// Macro IFID_PCPLUS4_EN adds out_pcplus4 to the bundle.
interface ifid_skid_stage_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_instr;
   logic [XLEN-1:0] in_pc;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_instr;
   logic [XLEN-1:0] out_pc;
   logic [1:0]      out_immsrc;
   logic [4:0]      out_rd;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic            out_illegal;
`ifdef IFID_PCPLUS4_EN
   logic [XLEN-1:0] out_pcplus4;
`endif

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_instr, out_pc, out_immsrc,
             out_rd, out_rs1, out_rs2, out_illegal
`ifdef IFID_PCPLUS4_EN
      , output out_pcplus4
`endif
   );

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, out_immsrc,
             out_rd, out_rs1, out_rs2, out_illegal
`ifdef IFID_PCPLUS4_EN
      , input out_pcplus4
`endif
   );
endinterface

// File: rtl/ifid_skid_stage.sv
// IF/ID register with a 2-entry skid buffer and opcode pre-decode for the extend unit.
// Optional macro IFID_PCPLUS4_EN registers pc+4 alongside the pc.
module ifid_skid_stage #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic                clk,
   input logic                rst_n,
   ifid_skid_stage_if.slave   bus
);

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   // Returns {illegal, immsrc}; R-type is legal with a don't-care immsrc.
   function automatic logic [2:0] decode(input logic [6:0] opc);
      case (opc)
         7'b0000011, 7'b0010011, 7'b1100111: decode = 3'b000;
         7'b0100011:                         decode = 3'b001;
         7'b1100011:                         decode = 3'b010;
         7'b1101111:                         decode = 3'b011;
         7'b0110011:                         decode = 3'b000;
         default:                            decode = 3'b100;
      endcase
   endfunction

   logic            out_valid_q, out_valid_d;
   logic            skid_valid_q, skid_valid_d;
   logic [XLEN-1:0] out_instr_q, out_instr_d;
   logic [XLEN-1:0] out_pc_q, out_pc_d;
   logic [1:0]      out_immsrc_q, out_immsrc_d;
   logic            out_illegal_q, out_illegal_d;
   logic [XLEN-1:0] skid_instr_q, skid_instr_d;
   logic [XLEN-1:0] skid_pc_q, skid_pc_d;
`ifdef IFID_PCPLUS4_EN
   logic [XLEN-1:0] out_pcplus4_q, out_pcplus4_d;
   logic [XLEN-1:0] skid_pcplus4_q, skid_pcplus4_d;
`endif

   logic       accept;
   logic       consume;
   logic [2:0] in_dec;
   logic [2:0] skid_dec;

   assign accept   = bus.in_valid && !skid_valid_q;
   assign consume  = out_valid_q && bus.out_ready;
   assign in_dec   = decode(bus.in_instr[6:0]);
   assign skid_dec = decode(skid_instr_q[6:0]);

   always_comb begin
      out_valid_d    = out_valid_q;
      skid_valid_d   = skid_valid_q;
      out_instr_d    = out_instr_q;
      out_pc_d       = out_pc_q;
      out_immsrc_d   = out_immsrc_q;
      out_illegal_d  = out_illegal_q;
      skid_instr_d   = skid_instr_q;
      skid_pc_d      = skid_pc_q;
`ifdef IFID_PCPLUS4_EN
      out_pcplus4_d  = out_pcplus4_q;
      skid_pcplus4_d = skid_pcplus4_q;
`endif
      if (bus.flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
         // in_ready is low here, so the only event is draining skid into out.
         if (consume) begin
            out_valid_d   = 1'b1;
            skid_valid_d  = 1'b0;
            out_instr_d   = skid_instr_q;
            out_pc_d      = skid_pc_q;
            out_immsrc_d  = skid_dec[1:0];
            out_illegal_d = skid_dec[2];
`ifdef IFID_PCPLUS4_EN
            out_pcplus4_d = skid_pcplus4_q;
`endif
         end
      end else if (accept) begin
         if (!out_valid_q || bus.out_ready) begin
            out_valid_d   = 1'b1;
            out_instr_d   = bus.in_instr;
            out_pc_d      = bus.in_pc;
            out_immsrc_d  = in_dec[1:0];
            out_illegal_d = in_dec[2];
`ifdef IFID_PCPLUS4_EN
            out_pcplus4_d = bus.in_pc + PC_STEP;
`endif
         end else begin
            skid_valid_d   = 1'b1;
            skid_instr_d   = bus.in_instr;
            skid_pc_d      = bus.in_pc;
`ifdef IFID_PCPLUS4_EN
            skid_pcplus4_d = bus.in_pc + PC_STEP;
`endif
         end
      end else if (consume) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q    <= 1'b0;
         skid_valid_q   <= 1'b0;
         out_instr_q    <= '0;
         out_pc_q       <= RESET_PC;
         out_immsrc_q   <= 2'b00;
         out_illegal_q  <= 1'b0;
         skid_instr_q   <= '0;
         skid_pc_q      <= RESET_PC;
`ifdef IFID_PCPLUS4_EN
         out_pcplus4_q  <= RESET_PC + PC_STEP;
         skid_pcplus4_q <= RESET_PC + PC_STEP;
`endif
      end else begin
         out_valid_q    <= out_valid_d;
         skid_valid_q   <= skid_valid_d;
         out_instr_q    <= out_instr_d;
         out_pc_q       <= out_pc_d;
         out_immsrc_q   <= out_immsrc_d;
         out_illegal_q  <= out_illegal_d;
         skid_instr_q   <= skid_instr_d;
         skid_pc_q      <= skid_pc_d;
`ifdef IFID_PCPLUS4_EN
         out_pcplus4_q  <= out_pcplus4_d;
         skid_pcplus4_q <= skid_pcplus4_d;
`endif
      end
   end

   assign bus.in_ready    = !skid_valid_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_instr   = out_instr_q;
   assign bus.out_pc      = out_pc_q;
   assign bus.out_immsrc  = out_immsrc_q;
   assign bus.out_illegal = out_illegal_q;
   assign bus.out_rd      = out_instr_q[11:7];
   assign bus.out_rs1     = out_instr_q[19:15];
   assign bus.out_rs2     = out_instr_q[24:20];
`ifdef IFID_PCPLUS4_EN
   assign bus.out_pcplus4 = out_pcplus4_q;
`endif

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Scoreboard bench for ifid_skid_stage: directed vectors with hand-decoded fields,
// monitor pops expectations whenever an output is consumed.
module tb_ifid_skid_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0080;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [1:0]  immsrc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        illegal;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   ifid_skid_stage_if #(.XLEN(32)) ifc ();

   ifid_skid_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [1:0] immsrc, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic illegal);
      exp_t e;
      e.instr = instr; e.pc = pc; e.immsrc = immsrc;
      e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.illegal = illegal;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: compare the presented output whenever decode consumes it.
   always @(negedge clk) begin
      exp_t act;
      exp_t e;
      if (rst_n && ifc.out_valid && ifc.out_ready && !ifc.flush) begin
         act = {ifc.out_instr, ifc.out_pc, ifc.out_immsrc, ifc.out_rd,
                ifc.out_rs1, ifc.out_rs2, ifc.out_illegal};
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL out_unexpected: got instr=%h pc=%h, expected nothing", act.instr, act.pc);
         end else begin
            e = sb.pop_front();
            if (act !== e) begin
               n_fail++;
               $display("FAIL out_xfer: got instr=%h pc=%h imm=%b rd=%0d rs1=%0d rs2=%0d ill=%b, expected instr=%h pc=%h imm=%b rd=%0d rs1=%0d rs2=%0d ill=%b",
                        act.instr, act.pc, act.immsrc, act.rd, act.rs1, act.rs2, act.illegal,
                        e.instr, e.pc, e.immsrc, e.rd, e.rs1, e.rs2, e.illegal);
            end
         end
      end
   end

   // One cycle of stimulus; the expectation is queued only if the stage accepts it.
   task automatic step(input logic v, input exp_t e, input logic ordy, input logic fl);
      ifc.in_valid  = v;
      ifc.in_instr  = e.instr;
      ifc.in_pc     = e.pc;
      ifc.out_ready = ordy;
      ifc.flush     = fl;
      @(negedge clk);
      if (fl) sb.delete();
      else if (v && ifc.in_ready) sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t nop, lw, sw, beq, jal, addi, add, jalr, zero, lwhi;
      nop  = mk(32'h0, 32'h0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
      lw   = mk(32'hFFC4A303, 32'h0000_0100, 2'b00, 5'd6,  5'd9, 5'd28, 1'b0);
      sw   = mk(32'h0064A423, 32'h0000_0104, 2'b01, 5'd8,  5'd9, 5'd6,  1'b0);
      beq  = mk(32'hFE420AE3, 32'h0000_0108, 2'b10, 5'd21, 5'd4, 5'd4,  1'b0);
      jal  = mk(32'h0000006F, 32'h0000_010C, 2'b11, 5'd0,  5'd0, 5'd0,  1'b0);
      addi = mk(32'h00500093, 32'h0000_0200, 2'b00, 5'd1,  5'd0, 5'd5,  1'b0);
      add  = mk(32'h003100B3, 32'h0000_0204, 2'b00, 5'd1,  5'd2, 5'd3,  1'b0);
      jalr = mk(32'h000080E7, 32'h0000_0208, 2'b00, 5'd1,  5'd1, 5'd0,  1'b0);
      zero = mk(32'h00000000, 32'h0000_0300, 2'b00, 5'd0,  5'd0, 5'd0,  1'b1);
      lwhi = mk(32'hFFC4A303, 32'hFFFF_FFFC, 2'b00, 5'd6,  5'd9, 5'd28, 1'b0);

      rst_n = 1'b0;
      ifc.in_valid = 1'b0; ifc.in_instr = '0; ifc.in_pc = '0;
      ifc.out_ready = 1'b0; ifc.flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("rst_in_ready",  32'(ifc.in_ready),  32'd1);
      chk("rst_out_pc",    ifc.out_pc,         RST_PC);
      chk("rst_out_instr", ifc.out_instr,      32'h0);
      chk("rst_fields",    {17'd0, ifc.out_immsrc, ifc.out_rd, ifc.out_rs1, ifc.out_rs2, ifc.out_illegal}, 32'h0);
`ifdef IFID_PCPLUS4_EN
      chk("rst_pcplus4",   ifc.out_pcplus4,    RST_PC + 32'd4);
`endif
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single I-type load, one-cycle latency.
      step(1'b1, lw, 1'b1, 1'b0);
      chk("lat_out_valid", 32'(ifc.out_valid), 32'd1);
      step(1'b0, nop, 1'b1, 1'b0);
      chk("idle_out_valid", 32'(ifc.out_valid), 32'd0);

      // Back-to-back S/B/J with decode always ready.
      step(1'b1, sw, 1'b1, 1'b0);
      chk("b2b_in_ready0", 32'(ifc.in_ready), 32'd1);
      step(1'b1, beq, 1'b1, 1'b0);
      chk("b2b_in_ready1", 32'(ifc.in_ready), 32'd1);
      step(1'b1, jal, 1'b1, 1'b0);
      chk("b2b_in_ready2", 32'(ifc.in_ready), 32'd1);
      step(1'b0, nop, 1'b1, 1'b0);

      // Backpressure fills out then skid; third is held off until the drain.
      step(1'b1, addi, 1'b0, 1'b0);
      step(1'b1, add,  1'b0, 1'b0);
      chk("skid_in_ready", 32'(ifc.in_ready), 32'd0);
      chk("skid_hold0",    ifc.out_instr,     addi.instr);
      step(1'b1, jalr, 1'b0, 1'b0);
      chk("skid_hold1",    ifc.out_instr,     addi.instr);
      chk("skid_block",    32'(ifc.in_ready), 32'd0);
      step(1'b1, jalr, 1'b1, 1'b0);
      chk("drain_in_ready", 32'(ifc.in_ready), 32'd1);
      step(1'b1, jalr, 1'b1, 1'b0);
      step(1'b0, nop,  1'b1, 1'b0);

      // Flush with out and skid full plus a same-cycle accept attempt.
      step(1'b1, sw,  1'b0, 1'b0);
      step(1'b1, beq, 1'b0, 1'b0);
      step(1'b1, jal, 1'b0, 1'b1);
      chk("flush_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("flush_in_ready",  32'(ifc.in_ready),  32'd1);
      step(1'b0, nop, 1'b1, 1'b0);
      step(1'b0, nop, 1'b1, 1'b0);

      // Unsupported opcode.
      step(1'b1, zero, 1'b1, 1'b0);
      step(1'b0, nop,  1'b1, 1'b0);

      // pc+4 wrap at the top of the address space.
      step(1'b1, lwhi, 1'b0, 1'b0);
`ifdef IFID_PCPLUS4_EN
      chk("pcplus4_wrap", ifc.out_pcplus4, 32'h0000_0000);
`endif
      step(1'b0, nop, 1'b1, 1'b0);

      // Asynchronous reset with both entries held.
      step(1'b1, addi, 1'b0, 1'b0);
      step(1'b1, add,  1'b0, 1'b0);
      ifc.in_valid = 1'b0;
      sb.delete();
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("mid_rst_in_ready",  32'(ifc.in_ready),  32'd1);
      chk("mid_rst_out_pc",    ifc.out_pc,         RST_PC);
      chk("mid_rst_out_instr", ifc.out_instr,      32'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      step(1'b0, nop, 1'b1, 1'b0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ifid_skid_stage.md
Name: ifid_skid_stage

Overview:
- IF/ID pipeline stage between instruction fetch and the decode/extend logic of the X-RISC RV32I core.
- Registers fetched instruction and PC behind a 2-entry skid buffer with valid/ready handshakes on both sides.
- Pre-decodes opcode into the 2-bit immsrc consumed by the extend unit, plus the register fields.
- Supports synchronous flush for taken branches and jumps.

Parameters:
- XLEN, 32, width of instr, pc and pc-derived outputs.
- RESET_PC, 32'h0000_0000, value driven on out_pc while out_valid is low after reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  fetch presents instr/pc.
- in_ready  output  1  stage can accept; equals !skid_valid (registered source).
- in_instr  input  XLEN  fetched instruction.
- in_pc  input  XLEN  fetched PC.
- flush  input  1  discard all held instructions.
- out_valid  output  1  out_* fields hold a valid instruction.
- out_ready  input  1  decode consumes this cycle.
- out_instr  output  XLEN  instruction to decode/extend unit.
- out_pc  output  XLEN  PC of out_instr.
- out_immsrc  output  2  immediate format select: 00 I, 01 S, 10 B, 11 J.
- out_rd  output  5  instr[11:7].
- out_rs1  output  5  instr[19:15].
- out_rs2  output  5  instr[24:20].
- out_illegal  output  1  opcode not in supported set.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, skid_valid=0, in_ready=1.
  - out_instr=0, out_pc=RESET_PC, out_immsrc=00, out_rd/rs1/rs2=0, out_illegal=0.
- Accept: in_valid && in_ready. Consume: out_valid && out_ready.
- Data path when out register is free (!out_valid or consume this cycle): accepted data loads the out register. Latency is 1 cycle, in_valid to out_valid.
- Data path when out register is held and not consumed: accepted data loads the skid register. skid_valid=1, so in_ready=0 next cycle.
- Skid drain: on consume while skid_valid=1, skid moves to out and skid_valid clears. A simultaneous new accept cannot occur because in_ready=0.
- Throughput: 1 instruction/cycle when out_ready held high. Ordering is strictly FIFO.
- out_* stay stable while out_valid=1 and out_ready=0.
- Decode is computed at register load and stored, not combinational on the output. Opcode mapping:
  - 0000011, 0010011, 1100111 → 00.
  - 0100011 → 01.
  - 1100011 → 10.
  - 1101111 → 11.
  - 0110011 → 00 (immsrc don't-care, not illegal).
  - Any other opcode → immsrc 00, out_illegal=1.
- Flush (synchronous):
  - Next edge clears out_valid and skid_valid.
  - Any same-cycle accept is discarded.
  - Flush has priority over accept and consume.
  - Data registers need not clear.
- Reset mid-operation: immediate return to reset values; held instructions are lost.
- in_valid with in_ready=0: no state change. Fetch must hold its data.

Optional Feature:
- Macro IFID_PCPLUS4_EN.
- Defined:
  - Adds output out_pcplus4 (XLEN), registered alongside out_pc and skid pc.
  - Equals in_pc+4, modulo 2^XLEN (wraps: 0xFFFF_FFFC → 0x0000_0000).
  - Reset value RESET_PC+4.
- Undefined: port and registers absent; all other behaviour identical.

Test Plan:
- Reset, then in_instr=32'hFFC4A303, in_pc=32'h100, in_valid=1, out_ready=1 → next cycle out_valid=1, out_immsrc=00, out_rd=6, out_rs1=9, out_illegal=0, out_pc=32'h100.
- Back-to-back 32'h0064A423 (sw), 32'hFE420AE3 (beq), 32'h0000006F (jal), out_ready=1 → out_immsrc 01, 10, 11 on consecutive cycles; in_ready stays 1.
- out_ready=0, push two instrs → second lands in skid, in_ready=0, third held off. Raise out_ready → first, second and third emerge in order; in_ready returns to 1 after the drain cycle.
- Out and skid both full, assert flush together with in_valid=1 → next cycle out_valid=0, in_ready=1, flushed and same-cycle instructions never appear.
- in_instr=32'h00000000 → out_illegal=1, out_immsrc=00. Drop rst_n mid-transfer → outputs immediately at reset values.
- IFID_PCPLUS4_EN: in_pc=32'hFFFF_FFFC → out_pcplus4=32'h0000_0000.
